// File: rtl/fetch_enqueue_unit.sv
// Fetch front end: owns the fetch PC, issues one I-memory read at a time and
// enqueues {pc, inst} into the instruction queue, with full backpressure and flush redirect.
module fetch_enqueue_unit #(
   parameter logic [31:0] RESET_PC    = 32'h1eceb000,
   parameter int          ENTRY_WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic [31:0]            imem_addr,
   output logic [3:0]             imem_rmask,
   input  logic [31:0]            imem_rdata,
   input  logic                   imem_resp,
   output logic                   iq_enqueue,
   output logic [ENTRY_WIDTH-1:0] iq_enqueue_wdata,
   input  logic                   iq_is_full,
   input  logic                   flush,
   input  logic [31:0]            flush_pc
);

   typedef enum logic [1:0] {
      START,
      REQ,
      HOLD,
      DISCARD
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] holdInst_q, holdInst_d;
   logic [31:0] redirectPc_q, redirectPc_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= START;
         pc_q         <= RESET_PC;
         holdInst_q   <= 32'h0;
         redirectPc_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         holdInst_q   <= holdInst_d;
         redirectPc_q <= redirectPc_d;
      end
   end

   assign imem_addr = pc_q;

   // DISCARD parks until the stale response drains, so at most one read is ever outstanding
   always_comb begin
      state_d          = state_q;
      pc_d             = pc_q;
      holdInst_d       = holdInst_q;
      redirectPc_d     = redirectPc_q;
      imem_rmask       = 4'h0;
      iq_enqueue       = 1'b0;
      iq_enqueue_wdata = '0;
      unique case (state_q)
         START: begin
            state_d = REQ;
         end
         REQ: begin
            imem_rmask = 4'hF;
            if (imem_resp) begin
               if (flush) begin
                  pc_d = flush_pc;
               end else if (!iq_is_full) begin
                  iq_enqueue       = 1'b1;
                  iq_enqueue_wdata = ENTRY_WIDTH'({pc_q, imem_rdata});
                  pc_d             = pc_q + 32'd4;
               end else begin
                  holdInst_d = imem_rdata;
                  state_d    = HOLD;
               end
            end else if (flush) begin
               redirectPc_d = flush_pc;
               state_d      = DISCARD;
            end
         end
         HOLD: begin
            if (flush) begin
               pc_d    = flush_pc;
               state_d = REQ;
            end else if (!iq_is_full) begin
               iq_enqueue       = 1'b1;
               iq_enqueue_wdata = ENTRY_WIDTH'({pc_q, holdInst_q});
               pc_d             = pc_q + 32'd4;
               state_d          = REQ;
            end
         end
         DISCARD: begin
            if (flush) begin
               redirectPc_d = flush_pc;
            end else if (imem_resp) begin
               pc_d    = redirectPc_q;
               state_d = REQ;
            end
         end
         default: begin
            state_d = START;
         end
      endcase
   end

endmodule

// File: tb/tb_fetch_enqueue_unit.sv
// Directed bench for fetch_enqueue_unit: per-cycle vector table plus a
// hand-written asynchronous reset sequence taken from the middle of HOLD.
module tb_fetch_enqueue_unit;

   localparam logic [31:0] RESET_PC = 32'h1eceb000;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [3:0]  imem_rmask;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic        iq_enqueue;
   logic [63:0] iq_enqueue_wdata;
   logic        iq_is_full;
   logic        flush;
   logic [31:0] flush_pc;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        rstN;
      logic        resp;
      logic [31:0] rdata;
      logic        full;
      logic        fl;
      logic [31:0] flPc;
      logic [3:0]  expRmask;
      logic [31:0] expAddr;
      logic        expEnq;
      logic [63:0] expWdata;
   } vec_t;

   vec_t vecs[$];

   fetch_enqueue_unit #(
      .RESET_PC    (RESET_PC),
      .ENTRY_WIDTH (64)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .imem_addr        (imem_addr),
      .imem_rmask       (imem_rmask),
      .imem_rdata       (imem_rdata),
      .imem_resp        (imem_resp),
      .iq_enqueue       (iq_enqueue),
      .iq_enqueue_wdata (iq_enqueue_wdata),
      .iq_is_full       (iq_is_full),
      .flush            (flush),
      .flush_pc         (flush_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] inst(input logic [31:0] pc);
      return pc ^ 32'hA5A5A5A5;
   endfunction

   task automatic addVec(input logic rstN, input logic resp, input logic [31:0] rdata,
                         input logic full, input logic fl, input logic [31:0] flPc,
                         input logic [3:0] expRmask, input logic [31:0] expAddr,
                         input logic expEnq, input logic [63:0] expWdata);
      vec_t v;
      v.rstN = rstN; v.resp = resp; v.rdata = rdata; v.full = full;
      v.fl = fl; v.flPc = flPc; v.expRmask = expRmask; v.expAddr = expAddr;
      v.expEnq = expEnq; v.expWdata = expWdata;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      rst_n      = v.rstN;
      imem_resp  = v.resp;
      imem_rdata = v.rdata;
      iq_is_full = v.full;
      flush      = v.fl;
      flush_pc   = v.flPc;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkAll(input string tag, input logic [3:0] rm, input logic [31:0] ad,
                           input logic en, input logic [63:0] wd);
      checkOutput({tag, ".rmask"}, 64'(imem_rmask), 64'(rm));
      checkOutput({tag, ".addr"}, 64'(imem_addr), 64'(ad));
      checkOutput({tag, ".enq"}, 64'(iq_enqueue), 64'(en));
      checkOutput({tag, ".wdata"}, iq_enqueue_wdata, wd);
   endtask

   initial begin
      rst_n = 1'b0; imem_resp = 1'b0; imem_rdata = '0;
      iq_is_full = 1'b0; flush = 1'b0; flush_pc = '0;

      // reset, START, then steady-state fetch with 1-cycle memory
      addVec(0, 0, 0, 0, 0, 0, 4'h0, RESET_PC, 0, 64'h0);
      addVec(1, 0, 0, 0, 0, 0, 4'h0, 32'h1eceb000, 0, 64'h0);
      addVec(1, 0, 0, 0, 0, 0, 4'hF, 32'h1eceb000, 0, 64'h0);
      addVec(1, 1, inst(32'h1eceb000), 0, 0, 0, 4'hF, 32'h1eceb000, 1, {32'h1eceb000, inst(32'h1eceb000)});
      addVec(1, 0, 0, 0, 0, 0, 4'hF, 32'h1eceb004, 0, 64'h0);
      // response while full, three full cycles in HOLD, then enqueue on the first non-full cycle
      addVec(1, 1, inst(32'h1eceb004), 1, 0, 0, 4'hF, 32'h1eceb004, 0, 64'h0);
      addVec(1, 0, 0, 1, 0, 0, 4'h0, 32'h1eceb004, 0, 64'h0);
      addVec(1, 0, 0, 1, 0, 0, 4'h0, 32'h1eceb004, 0, 64'h0);
      addVec(1, 0, 0, 1, 0, 0, 4'h0, 32'h1eceb004, 0, 64'h0);
      addVec(1, 0, 0, 0, 0, 0, 4'h0, 32'h1eceb004, 1, {32'h1eceb004, inst(32'h1eceb004)});
      addVec(1, 0, 0, 0, 0, 0, 4'hF, 32'h1eceb008, 0, 64'h0);
      addVec(1, 1, inst(32'h1eceb008), 0, 0, 0, 4'hF, 32'h1eceb008, 1, {32'h1eceb008, inst(32'h1eceb008)});
      // flush with the request outstanding; stale response two cycles later
      addVec(1, 0, 0, 0, 1, 32'h1ecf0000, 4'hF, 32'h1eceb00c, 0, 64'h0);
      addVec(1, 0, 0, 0, 0, 0, 4'h0, 32'h1eceb00c, 0, 64'h0);
      addVec(1, 1, inst(32'h1eceb00c), 0, 0, 0, 4'h0, 32'h1eceb00c, 0, 64'h0);
      // flush coincident with response
      addVec(1, 1, 32'hCAFEF00D, 0, 1, 32'h00003000, 4'hF, 32'h1ecf0000, 0, 64'h0);
      // two flushes in DISCARD: newest wins
      addVec(1, 0, 0, 0, 1, 32'h00000100, 4'hF, 32'h00003000, 0, 64'h0);
      addVec(1, 0, 0, 0, 1, 32'h00000200, 4'h0, 32'h00003000, 0, 64'h0);
      addVec(1, 1, 32'h11111111, 0, 0, 0, 4'h0, 32'h00003000, 0, 64'h0);
      addVec(1, 0, 0, 0, 0, 0, 4'hF, 32'h00000200, 0, 64'h0);
      // PC wrap from FFFFFFFC to 0
      addVec(1, 1, 32'h22222222, 0, 1, 32'hFFFFFFFC, 4'hF, 32'h00000200, 0, 64'h0);
      addVec(1, 1, 32'h12345678, 0, 0, 0, 4'hF, 32'hFFFFFFFC, 1, {32'hFFFFFFFC, 32'h12345678});
      addVec(1, 0, 0, 0, 0, 0, 4'hF, 32'h00000000, 0, 64'h0);
      // flush out of HOLD, then park in HOLD at 1eceb010
      addVec(1, 1, 32'h0000DEAD, 1, 0, 0, 4'hF, 32'h00000000, 0, 64'h0);
      addVec(1, 0, 0, 1, 1, 32'h1eceb010, 4'h0, 32'h00000000, 0, 64'h0);
      addVec(1, 1, 32'h0000BEEF, 1, 0, 0, 4'hF, 32'h1eceb010, 0, 64'h0);
      addVec(1, 0, 0, 1, 0, 0, 4'h0, 32'h1eceb010, 0, 64'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkAll($sformatf("vec%0d", i), vecs[i].expRmask, vecs[i].expAddr, vecs[i].expEnq, vecs[i].expWdata);
      end

      // async reset mid-HOLD; full drops at the same time, so a missed reset would enqueue
      @(negedge clk);
      #2;
      rst_n = 1'b0; iq_is_full = 1'b0; imem_resp = 1'b0; flush = 1'b0;
      #1;
      checkAll("asyncRst", 4'h0, RESET_PC, 1'b0, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkAll("postRstStart", 4'h0, RESET_PC, 1'b0, 64'h0);
      @(negedge clk);
      #1;
      checkAll("postRstReq", 4'hF, RESET_PC, 1'b0, 64'h0);
      @(negedge clk);
      imem_resp = 1'b1; imem_rdata = inst(RESET_PC);
      #1;
      checkAll("postRstEnq", 4'hF, RESET_PC, 1'b1, {RESET_PC, inst(RESET_PC)});
      @(negedge clk);
      imem_resp = 1'b0;
      #1;
      checkAll("postRstNext", 4'hF, RESET_PC + 32'd4, 1'b0, 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
